soft_reset_sequencer: RTL and testbench

Downstream consumer of the processor's system-control reset request. Takes the one-cycle software-reset pulse and its 4-bit reset vector, drives per-domain reset requests (instruction, IO, data) with req/ack handshakes or a timed full reset, and returns a one-cycle completion pulse that releases the control block's reset stall. It also applies a watchdog so a domain that never acknowledges cannot hang the core.

---
 rtl/soft_reset_sequencer.sv | 138 +++++++++++++
 tb/tb_soft_reset_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soft_reset_sequencer.sv
// Soft-reset sequencer: turns a one-cycle software reset request into per-domain
// req/ack handshakes or a timed full-core reset, then returns a one-cycle completion pulse.
// Latency: Req/FullResetOut one enabled cycle after the request; all outputs registered; clk_en=0 freezes everything.
module soft_reset_sequencer #(
  parameter int FULL_RESET_CYCLES = 16,   // 1..255
  parameter int ACK_TIMEOUT       = 255   // 1..65535
) (
  input  logic       clk,
  input  logic       async_rst_n,
  input  logic       clk_en,
  input  logic       SoftwareResetIn,
  input  logic [3:0] ResetVectorIn,
  output logic       InstResetReq,
  output logic       IOResetReq,
  output logic       DataResetReq,
  input  logic       InstResetAck,
  input  logic       IOResetAck,
  input  logic       DataResetAck,
  output logic       FullResetOut,
  output logic       ResetResponseOut,
  output logic       Busy,
  output logic       TimeoutFlag
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FULL_HOLD = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_RESPOND   = 2'd3
  } state_t;

  // Counter reload/terminal values; the full-hold counter counts down to 0,
  // the watchdog counts up from 0 and fires on its ACK_TIMEOUT-th WAIT_ACK edge.
  localparam logic [7:0]  FULL_LOAD = 8'(FULL_RESET_CYCLES - 1);
  localparam logic [15:0] WD_LAST   = 16'(ACK_TIMEOUT - 1);

  state_t      r_state;
  logic [2:0]  r_req;        // {inst, io, data}
  logic [7:0]  r_full_cnt;
  logic [15:0] r_wd_cnt;
  logic        r_full;
  logic        r_resp;
  logic        r_busy;
  logic        r_timeout;

  logic [2:0]  w_ack;
  logic [2:0]  w_req_next;
  logic        w_wd_expired;

  // Acks only clear a request that is still pending; stray acks fall out here.
  assign w_ack        = {InstResetAck, IOResetAck, DataResetAck};
  assign w_req_next   = r_req & ~w_ack;
  assign w_wd_expired = (r_wd_cnt == WD_LAST);

  // Sequencer FSM with all outputs held in registers.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_state    <= ST_IDLE;
      r_req      <= 3'b000;
      r_full_cnt <= 8'd0;
      r_wd_cnt   <= 16'd0;
      r_full     <= 1'b0;
      r_resp     <= 1'b0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (clk_en) begin
      case (r_state)
        ST_IDLE: begin
          if (SoftwareResetIn) begin
            r_timeout <= 1'b0;
            r_busy    <= 1'b1;
            r_wd_cnt  <= 16'd0;
            if (ResetVectorIn[3]) begin
              // Full reset covers every domain, so the per-domain bits are ignored.
              r_full     <= 1'b1;
              r_full_cnt <= FULL_LOAD;
              r_state    <= ST_FULL_HOLD;
            end else if (ResetVectorIn[2:0] != 3'b000) begin
              r_req   <= ResetVectorIn[2:0];
              r_state <= ST_WAIT_ACK;
            end else begin
              r_resp  <= 1'b1;
              r_state <= ST_RESPOND;
            end
          end
        end

        ST_FULL_HOLD: begin
          if (r_full_cnt == 8'd0) begin
            r_full  <= 1'b0;
            r_resp  <= 1'b1;
            r_state <= ST_RESPOND;
          end else begin
            r_full_cnt <= r_full_cnt - 8'd1;
          end
        end

        ST_WAIT_ACK: begin
          if (r_req == 3'b000) begin
            // Last Req dropped on the previous edge: report completion.
            r_resp  <= 1'b1;
            r_state <= ST_RESPOND;
          end else if (w_req_next == 3'b000) begin
            // Final ack(s) this edge; beats a coincident watchdog expiry.
            r_req <= 3'b000;
          end else if (w_wd_expired) begin
            r_req     <= 3'b000;
            r_timeout <= 1'b1;
            r_resp    <= 1'b1;
            r_state   <= ST_RESPOND;
          end else begin
            r_req    <= w_req_next;
            r_wd_cnt <= r_wd_cnt + 16'd1;
          end
        end

        ST_RESPOND: begin
          r_resp  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign InstResetReq     = r_req[2];
  assign IOResetReq       = r_req[1];
  assign DataResetReq     = r_req[0];
  assign FullResetOut     = r_full;
  assign ResetResponseOut = r_resp;
  assign Busy             = r_busy;
  assign TimeoutFlag      = r_timeout;

endmodule

// File: tb/tb_soft_reset_sequencer.sv
// Directed bench for soft_reset_sequencer: two instances share stimulus,
// u_s with ACK_TIMEOUT=8 and u_l with the default 255, both FULL_RESET_CYCLES=16.
// Output vectors are packed {full, inst, io, data, resp, busy, timeout}.
module tb_soft_reset_sequencer;

  logic       clk = 1'b0;
  logic       async_rst_n;
  logic       clk_en;
  logic       sw;
  logic [3:0] vec;
  logic       inst_ack, io_ack, data_ack;

  logic s_inst, s_io, s_data, s_full, s_resp, s_busy, s_to;
  logic l_inst, l_io, l_data, l_full, l_resp, l_busy, l_to;
  logic [6:0] s_out, l_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign s_out = {s_full, s_inst, s_io, s_data, s_resp, s_busy, s_to};
  assign l_out = {l_full, l_inst, l_io, l_data, l_resp, l_busy, l_to};

  soft_reset_sequencer #(.FULL_RESET_CYCLES(16), .ACK_TIMEOUT(8)) u_s (
    .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en),
    .SoftwareResetIn(sw), .ResetVectorIn(vec),
    .InstResetReq(s_inst), .IOResetReq(s_io), .DataResetReq(s_data),
    .InstResetAck(inst_ack), .IOResetAck(io_ack), .DataResetAck(data_ack),
    .FullResetOut(s_full), .ResetResponseOut(s_resp), .Busy(s_busy), .TimeoutFlag(s_to)
  );

  soft_reset_sequencer #(.FULL_RESET_CYCLES(16), .ACK_TIMEOUT(255)) u_l (
    .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en),
    .SoftwareResetIn(sw), .ResetVectorIn(vec),
    .InstResetReq(l_inst), .IOResetReq(l_io), .DataResetReq(l_data),
    .InstResetAck(inst_ack), .IOResetAck(io_ack), .DataResetAck(data_ack),
    .FullResetOut(l_full), .ResetResponseOut(l_resp), .Busy(l_busy), .TimeoutFlag(l_to)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [3:0] v);
    sw  = 1'b1;
    vec = v;
    tick();
    sw  = 1'b0;
    vec = 4'b0000;
  endtask

  task automatic test_reset();
    async_rst_n = 1'b0;
    clk_en = 1'b1; sw = 1'b0; vec = 4'b0000;
    inst_ack = 1'b0; io_ack = 1'b0; data_ack = 1'b0;
    #12;
    checks++;
    if ({s_out, l_out} !== 14'b0) begin
      errors++; $display("FAIL reset_state got s=%b l=%b want 0", s_out, l_out);
    end
    @(posedge clk); #3 async_rst_n = 1'b1;
    tick();
    checks++;
    if ({s_out, l_out} !== 14'b0) begin
      errors++; $display("FAIL post_reset_idle got s=%b l=%b want 0", s_out, l_out);
    end
  endtask

  task automatic test_full_hold();
    request(4'b1000);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({s_out, l_out} !== {7'b1000010, 7'b1000010}) begin
        errors++; $display("FAIL full_hold i=%0d got s=%b l=%b want 1000010", i, s_out, l_out);
      end
      tick();
    end
    checks++;
    if ({s_out, l_out} !== {7'b0000110, 7'b0000110}) begin
      errors++; $display("FAIL full_respond got s=%b l=%b want 0000110", s_out, l_out);
    end
    tick();
    checks++;
    if ({s_out, l_out} !== 14'b0) begin
      errors++; $display("FAIL full_idle got s=%b l=%b want 0", s_out, l_out);
    end
  endtask

  task automatic test_full_hold_clk_en();
    request(4'b1000);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if ({s_out, l_out} !== {7'b1000010, 7'b1000010}) begin
        errors++; $display("FAIL full_en_hold clk=%0d got s=%b l=%b want 1000010", i, s_out, l_out);
      end
      clk_en = (i % 2 == 1);
      tick();
    end
    checks++;
    if ({s_out, l_out} !== {7'b0000110, 7'b0000110}) begin
      errors++; $display("FAIL full_en_respond got s=%b l=%b want 0000110", s_out, l_out);
    end
    clk_en = 1'b0;
    tick();
    checks++;
    if ({s_out, l_out} !== {7'b0000110, 7'b0000110}) begin
      errors++; $display("FAIL full_en_resp_hold got s=%b l=%b want 0000110", s_out, l_out);
    end
    clk_en = 1'b1;
    tick();
    checks++;
    if ({s_out, l_out} !== 14'b0) begin
      errors++; $display("FAIL full_en_idle got s=%b l=%b want 0", s_out, l_out);
    end
  endtask

  task automatic test_zero_vector();
    request(4'b0000);
    checks++;
    if ({s_out, l_out} !== {7'b0000110, 7'b0000110}) begin
      errors++; $display("FAIL zero_respond got s=%b l=%b want 0000110", s_out, l_out);
    end
    tick();
    checks++;
    if ({s_out, l_out} !== 14'b0) begin
      errors++; $display("FAIL zero_idle got s=%b l=%b want 0", s_out, l_out);
    end
  endtask

  // u_l completes by acks; u_s has its watchdog fire at edge N+8 before the IO ack.
  task automatic test_ack_order();
    logic [6:0] exp_s, exp_l;
    request(4'b0111);
    checks++;
    if ({s_out, l_out} !== {7'b0111010, 7'b0111010}) begin
      errors++; $display("FAIL ack_start got s=%b l=%b want 0111010", s_out, l_out);
    end
    for (int k = 1; k <= 11; k++) begin
      data_ack = (k == 3);
      inst_ack = (k == 5);
      io_ack   = (k == 9);
      tick();
      exp_l = (k <= 2) ? 7'b0111010 : (k <= 4) ? 7'b0110010 : (k <= 8) ? 7'b0010010 :
              (k == 9) ? 7'b0000010 : (k == 10) ? 7'b0000110 : 7'b0000000;
      exp_s = (k <= 2) ? 7'b0111010 : (k <= 4) ? 7'b0110010 : (k <= 7) ? 7'b0010010 :
              (k == 8) ? 7'b0000111 : 7'b0000001;
      checks++;
      if (l_out !== exp_l) begin
        errors++; $display("FAIL ack_order_l k=%0d got %b want %b", k, l_out, exp_l);
      end
      checks++;
      if (s_out !== exp_s) begin
        errors++; $display("FAIL ack_watchdog_s k=%0d got %b want %b", k, s_out, exp_s);
      end
    end
    data_ack = 1'b0; inst_ack = 1'b0; io_ack = 1'b0;
  endtask

  task automatic test_timeout();
    logic [6:0] exp_s;
    request(4'b0010);
    checks++;
    if ({s_out, l_out} !== {7'b0010010, 7'b0010010}) begin
      errors++; $display("FAIL to_start got s=%b l=%b want 0010010", s_out, l_out);
    end
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_s = (k <= 7) ? 7'b0010010 : (k == 8) ? 7'b0000111 : 7'b0000001;
      checks++;
      if ({s_out, l_out} !== {exp_s, 7'b0010010}) begin
        errors++; $display("FAIL timeout k=%0d got s=%b l=%b want s=%b l=0010010", k, s_out, l_out, exp_s);
      end
    end
    io_ack = 1'b1;
    tick();
    io_ack = 1'b0;
    checks++;
    if ({s_out, l_out} !== {7'b0000001, 7'b0000010}) begin
      errors++; $display("FAIL to_late_ack got s=%b l=%b want s=0000001 l=0000010", s_out, l_out);
    end
    tick();
    checks++;
    if ({s_out, l_out} !== {7'b0000001, 7'b0000110}) begin
      errors++; $display("FAIL to_l_respond got s=%b l=%b want s=0000001 l=0000110", s_out, l_out);
    end
    tick();
    checks++;
    if ({s_out, l_out} !== {7'b0000001, 7'b0000000}) begin
      errors++; $display("FAIL to_sticky got s=%b l=%b want s=0000001 l=0", s_out, l_out);
    end
  endtask

  task automatic test_flag_clear();
    request(4'b0000);
    checks++;
    if ({s_out, l_out} !== {7'b0000110, 7'b0000110}) begin
      errors++; $display("FAIL flag_clear got s=%b l=%b want 0000110", s_out, l_out);
    end
    tick();
    checks++;
    if ({s_out, l_out} !== 14'b0) begin
      errors++; $display("FAIL flag_clear_idle got s=%b l=%b want 0", s_out, l_out);
    end
  endtask

  task automatic test_drop_and_spurious();
    request(4'b0011);
    checks++;
    if ({s_out, l_out} !== {7'b0011010, 7'b0011010}) begin
      errors++; $display("FAIL drop_start got s=%b l=%b want 0011010", s_out, l_out);
    end
    sw = 1'b1; vec = 4'b1000; inst_ack = 1'b1;
    tick();
    sw = 1'b0; vec = 4'b0000; inst_ack = 1'b0;
    checks++;
    if ({s_out, l_out} !== {7'b0011010, 7'b0011010}) begin
      errors++; $display("FAIL drop_ignored got s=%b l=%b want 0011010", s_out, l_out);
    end
    io_ack = 1'b1; data_ack = 1'b1;
    tick();
    io_ack = 1'b0; data_ack = 1'b0;
    checks++;
    if ({s_out, l_out} !== {7'b0000010, 7'b0000010}) begin
      errors++; $display("FAIL drop_dual_ack got s=%b l=%b want 0000010", s_out, l_out);
    end
    tick();
    checks++;
    if ({s_out, l_out} !== {7'b0000110, 7'b0000110}) begin
      errors++; $display("FAIL drop_respond got s=%b l=%b want 0000110", s_out, l_out);
    end
    tick();
    checks++;
    if ({s_out, l_out} !== 14'b0) begin
      errors++; $display("FAIL drop_idle got s=%b l=%b want 0", s_out, l_out);
    end
  endtask

  task automatic test_async_abort();
    request(4'b1000);
    repeat (4) tick();
    checks++;
    if ({s_out, l_out} !== {7'b1000010, 7'b1000010}) begin
      errors++; $display("FAIL abort_pre got s=%b l=%b want 1000010", s_out, l_out);
    end
    #2 async_rst_n = 1'b0;
    #1;
    checks++;
    if ({s_out, l_out} !== 14'b0) begin
      errors++; $display("FAIL abort_immediate got s=%b l=%b want 0", s_out, l_out);
    end
    repeat (2) @(posedge clk);
    #3 async_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({s_out, l_out} !== 14'b0) begin
        errors++; $display("FAIL abort_quiet i=%0d got s=%b l=%b want 0", i, s_out, l_out);
      end
    end
    request(4'b0100);
    checks++;
    if ({s_out, l_out} !== {7'b0100010, 7'b0100010}) begin
      errors++; $display("FAIL abort_next_req got s=%b l=%b want 0100010", s_out, l_out);
    end
    inst_ack = 1'b1;
    tick();
    inst_ack = 1'b0;
    checks++;
    if ({s_out, l_out} !== {7'b0000010, 7'b0000010}) begin
      errors++; $display("FAIL abort_next_ack got s=%b l=%b want 0000010", s_out, l_out);
    end
    tick();
    checks++;
    if ({s_out, l_out} !== {7'b0000110, 7'b0000110}) begin
      errors++; $display("FAIL abort_next_resp got s=%b l=%b want 0000110", s_out, l_out);
    end
    tick();
    checks++;
    if ({s_out, l_out} !== 14'b0) begin
      errors++; $display("FAIL abort_next_idle got s=%b l=%b want 0", s_out, l_out);
    end
  endtask

  initial begin
    test_reset();
    test_full_hold();
    test_full_hold_clk_en();
    test_zero_vector();
    test_ack_order();
    test_timeout();
    test_flag_clear();
    test_drop_and_spurious();
    test_async_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
